// File: rtl/fifo_param_pkg.sv
// Shared FIFO defaults and pointer sizing helper.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package fifo_param_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 32;

  // Pointer width: address bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x WIDTH register array, one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port after the write edge; read is combinational.
// Backpressure: none; the caller only asserts wr_en for accepted writes.
module fifo_mem
  import fifo_param_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = ptr_w(DEPTH) - 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_dat
);

  // Storage is deliberately not reset; stale words are never exposed because occupancy gates reads.
  logic [WIDTH-1:0] mem [DEPTH];

  // Store the incoming word at the write address.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/fifo_param.sv
// fifo_param: single-clock parameterised FIFO with occupancy count, threshold flags and sticky errors.
// Latency: flags 1 cycle after the causing edge; read data 1 cycle after pop (FWFT=0) or head shown 1 cycle after write (FWFT=1).
// Backpressure: writes dropped while Full (sets Overflow), reads dropped while Empty (sets Underflow).
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_TH  = DEPTH - 4,
  parameter int AEMPTY_TH = 4,
  parameter int FWFT      = 0
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      WrEnable,
  input  logic [WIDTH-1:0]          WrData,
  input  logic                      RdEnable,
  input  logic                      ClearErr,
  output logic [WIDTH-1:0]          RdData,
  output logic                      RdValid,
  output logic                      Full,
  output logic                      Empty,
  output logic                      AlmostFull,
  output logic                      AlmostEmpty,
  output logic [ptr_w(DEPTH)-1:0]   Count,
  output logic                      Overflow,
  output logic                      Underflow
);

  localparam int            PW      = ptr_w(DEPTH);
  localparam int            AW      = PW - 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AFULL_TH);
  localparam logic [PW-1:0] AE_C    = PW'(AEMPTY_TH);
  localparam logic [PW-1:0] ONE     = PW'(1);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_acc;
  logic             rd_acc;
  logic [WIDTH-1:0] mem_rdata;

  // Flags decode the registered count, so they trail the causing edge by one cycle.
  assign Full        = (Count == DEPTH_C);
  assign Empty       = (Count == '0);
  assign AlmostFull  = (Count >= AF_C);
  assign AlmostEmpty = (Count <= AE_C);

  // A full FIFO still pops on a simultaneous request; an empty one still pushes.
  assign wr_acc = WrEnable & ~Full;
  assign rd_acc = RdEnable & ~Empty;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (Clock),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_dat  (WrData),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_dat  (mem_rdata)
  );

  // Advance pointers on accepted transfers and track occupancy.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
      case ({wr_acc, rd_acc})
        2'b10:   Count <= Count + ONE;
        2'b01:   Count <= Count - ONE;
        default: Count <= Count;
      endcase
    end
  end

  // Sticky error flags; a fresh error in the clearing cycle keeps the flag set.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      if (WrEnable && Full)       Overflow  <= 1'b1;
      else if (ClearErr)          Overflow  <= 1'b0;
      if (RdEnable && Empty)      Underflow <= 1'b1;
      else if (ClearErr)          Underflow <= 1'b0;
    end
  end

  // Occupancy must always equal the pointer distance, wrap bits included.
  assert property (@(posedge Clock) disable iff (!Reset) Count == (wr_ptr - rd_ptr));

  if (FWFT == 0) begin : g_std
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_vld_q;

    // Capture the head word on a pop; valid pulses for the following cycle only.
    always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
        rd_data_q <= '0;
        rd_vld_q  <= 1'b0;
      end else begin
        rd_vld_q <= rd_acc;
        if (rd_acc) rd_data_q <= mem_rdata;
      end
    end

    assign RdData  = rd_data_q;
    assign RdValid = rd_vld_q;
  end else begin : g_fwft
    // Head word is shown directly; forced to zero when nothing is stored so reset reads as 0.
    assign RdData  = Empty ? '0 : mem_rdata;
    assign RdValid = ~Empty;
  end

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed + random scoreboard bench for fifo_param, standard and FWFT instances side by side.
// Latency: checks sampled 1 ns after each rising edge against a queue model.
// Backpressure: model drops writes when 32 words are held and reads when empty.
module tb_fifo_param;

  logic clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_dat;
  logic       rd_en;
  logic       clr_err;

  logic [7:0] rd0, rd1;
  logic       rv0, rv1, full0, full1, empty0, empty1, af0, af1, ae0, ae1, ov0, ov1, un0, un1;
  logic [5:0] cnt0, cnt1;

  fifo_param #(.WIDTH(8), .DEPTH(32), .FWFT(0)) dut0 (
    .Clock(clk100), .Reset(rst_n), .WrEnable(wr_en), .WrData(wr_dat), .RdEnable(rd_en),
    .ClearErr(clr_err), .RdData(rd0), .RdValid(rv0), .Full(full0), .Empty(empty0),
    .AlmostFull(af0), .AlmostEmpty(ae0), .Count(cnt0), .Overflow(ov0), .Underflow(un0)
  );

  fifo_param #(.WIDTH(8), .DEPTH(32), .FWFT(1)) dut1 (
    .Clock(clk100), .Reset(rst_n), .WrEnable(wr_en), .WrData(wr_dat), .RdEnable(rd_en),
    .ClearErr(clr_err), .RdData(rd1), .RdValid(rv1), .Full(full1), .Empty(empty1),
    .AlmostFull(af1), .AlmostEmpty(ae1), .Count(cnt1), .Overflow(ov1), .Underflow(un1)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  logic       exp_ov, exp_un, exp_rv;
  logic [7:0] exp_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output of both instances against the queue model.
  task automatic check_state();
    int         n;
    logic [7:0] head;
    n    = sb.size();
    head = (n != 0) ? sb[0] : 8'h00;
    chk("count",        cnt0,   n);
    chk("full",         full0,  n == 32);
    chk("empty",        empty0, n == 0);
    chk("almost_full",  af0,    n >= 28);
    chk("almost_empty", ae0,    n <= 4);
    chk("overflow",     ov0,    exp_ov);
    chk("underflow",    un0,    exp_un);
    chk("rd_valid",     rv0,    exp_rv);
    chk("rd_data",      rd0,    exp_rd);
    chk("fwft_count",   cnt1,   n);
    chk("fwft_full",    full1,  n == 32);
    chk("fwft_empty",   empty1, n == 0);
    chk("fwft_af",      af1,    n >= 28);
    chk("fwft_ae",      ae1,    n <= 4);
    chk("fwft_ovf",     ov1,    exp_ov);
    chk("fwft_unf",     un1,    exp_un);
    chk("fwft_valid",   rv1,    n != 0);
    chk("fwft_data",    rd1,    head);
  endtask

  // One clock of stimulus: drive, update the scoreboard across the edge, then check.
  task automatic step(input logic we, input logic [7:0] wd, input logic re, input logic ce);
    logic w_ok, r_ok;
    wr_en = we; wr_dat = wd; rd_en = re; clr_err = ce;
    w_ok = we && (sb.size() < 32);
    r_ok = re && (sb.size() > 0);
    @(posedge clk100); #1;
    if (r_ok) exp_rd = sb.pop_front();
    if (w_ok) sb.push_back(wd);
    if (we && !w_ok) exp_ov = 1'b1; else if (ce) exp_ov = 1'b0;
    if (re && !r_ok) exp_un = 1'b1; else if (ce) exp_un = 1'b0;
    exp_rv = r_ok;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    check_state();
  endtask

  task automatic model_reset();
    sb.delete();
    exp_ov = 1'b0; exp_un = 1'b0; exp_rv = 1'b0; exp_rd = 8'h00;
  endtask

  initial begin
    int   wl, rl, guard;
    logic w, r;

    rst_n = 1'b1; wr_en = 1'b0; wr_dat = 8'h00; rd_en = 1'b0; clr_err = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_state();

    // Write request held across an edge while reset is low must be ignored.
    wr_en = 1'b1; wr_dat = 8'hEE; rd_en = 1'b1;
    @(posedge clk100); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    check_state();
    rst_n = 1'b1;

    // Fill to full with 0x01..0x20.
    for (int i = 1; i <= 32; i++) step(1'b1, 8'(i), 1'b0, 1'b0);

    // Rejected write, then simultaneous read+write at full, then clear.
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    step(1'b1, 8'hBB, 1'b1, 1'b0);
    chk("first_word", rd0, 8'h01);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Drain.
    while (sb.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Underflow, simultaneous on empty, set-wins over clear, then clear.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Read latency: FWFT shows 0x3C before any read; standard pulses valid after the read edge.
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("fwft_3c", rd1, 8'h3C);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("std_3c", rd0, 8'h3C);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Random interleave: 100 write and 102 read requests.
    wl = 100; rl = 102; guard = 0;
    while ((wl > 0 || rl > 0) && guard < 4000) begin
      w = (wl > 0) && ($urandom_range(0, 1) == 1);
      r = (rl > 0) && ($urandom_range(0, 1) == 1);
      if (w) wl--;
      if (r) rl--;
      step(w, 8'($urandom), r, 1'b0);
      guard++;
    end
    chk("random_budget", guard < 4000, 1'b1);
    while (sb.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Mid-operation reset with 17 words and a pending error.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_state();
    @(posedge clk100); #1;
    rst_n = 1'b1;
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b1, 8'h78, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_reset_0", rd0, 8'h77);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_reset_1", rd0, 8'h78);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
